// File: rtl/sram_controller.sv
// Bridges 32-bit load/store requests to a 16-bit external SRAM as two sequential
// half-word phases (low half first), holding ready low while an access is in flight.
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 3,
  parameter int unsigned BASE_ADDR    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  inout  wire  [15:0] SRAM_DQ
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WIDX_W = 17;
  localparam int unsigned SADR_W = 18;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic [SADR_W-1:0]   sram_addr_q, sram_addr_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [HALF_W-1:0]   dq_out_q, dq_out_d;

  logic [DATA_W-1:0]   off_c;
  logic [WIDX_W-1:0]   widx_c;
  logic                last_c;
  logic                acc_d_c;

  // Word index is off[18:2]; the byte offset bits are dropped by the shift.
  assign off_c  = address - DATA_W'(BASE_ADDR);
  assign widx_c = WIDX_W'(off_c >> 2);
  assign last_c = (cnt_q == CNT_W'(PHASE_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wr_en || rd_en) begin
          is_wr_d = wr_en;
          widx_d  = widx_c;
          wdata_d = write_data;
          state_d = ACC_LO;
        end
      end
      ACC_LO: begin
        if (!is_wr_q && last_c) read_data_d[15:0] = SRAM_DQ;
        if (last_c) begin
          cnt_d   = '0;
          state_d = ACC_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACC_HI: begin
        if (!is_wr_q && last_c) read_data_d[31:16] = SRAM_DQ;
        if (last_c) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pins are registered from the next state so they line up with state_q.
  always_comb begin
    sram_addr_d = '0;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = '0;
    acc_d_c     = (state_d == ACC_LO) || (state_d == ACC_HI);
    if (acc_d_c) begin
      sram_addr_d = {widx_d, (state_d == ACC_HI)};
      we_n_d      = !is_wr_d;
      dq_oe_d     = is_wr_d;
      dq_out_d    = (state_d == ACC_HI) ? wdata_d[31:16] : wdata_d[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      widx_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      widx_q      <= widx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // ready is combinational so a new request freezes the pipeline immediately.
  assign ready     = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);
  assign read_data = read_data_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: table of load/store vectors against a P=3
// instance with an SRAM model, plus reset, back-to-back and P=1 sequences.
module tb_sram_controller;

  localparam int P = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_en, wr_en, sram_oe;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready, sram_we_n;
  wire  [17:0] sram_addr;
  wire  [15:0] sram_dq;

  logic        rd_en_1, wr_en_1;
  logic [31:0] address_1, write_data_1;
  wire  [31:0] read_data_1;
  wire         ready_1, sram_we_n_1;
  wire  [17:0] sram_addr_1;
  wire  [15:0] sram_dq_1;

  logic [15:0] mem  [0:255];
  logic [15:0] mem1 [0:255];

  sram_controller #(.PHASE_CYCLES(P), .BASE_ADDR(1024)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_DQ(sram_dq));

  sram_controller #(.PHASE_CYCLES(1), .BASE_ADDR(1024)) u_dut_p1 (
    .clk(clk), .rst(rst), .rd_en(rd_en_1), .wr_en(wr_en_1), .address(address_1),
    .write_data(write_data_1), .read_data(read_data_1), .ready(ready_1),
    .SRAM_ADDR(sram_addr_1), .SRAM_WE_N(sram_we_n_1), .SRAM_DQ(sram_dq_1));

  // Asynchronous-read SRAM models; sram_oe lets the bench observe an undriven bus.
  assign sram_dq   = (sram_oe && sram_we_n)   ? mem[sram_addr[7:0]]    : 16'hzzzz;
  assign sram_dq_1 = (sram_oe && sram_we_n_1) ? mem1[sram_addr_1[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n)   mem[sram_addr[7:0]]    <= sram_dq;
    if (!sram_we_n_1) mem1[sram_addr_1[7:0]] <= sram_dq_1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  // Runs one access on the P=3 instance; returns at DONE (+1) with inputs dropped.
  task automatic run_access(input vec_t v, output logic rdy0, output int ncyc,
                            output int nwe, output logic [17:0] a_lo, output logic [17:0] a_hi);
    bit done;
    @(posedge clk); #1;
    @(negedge clk);
    wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
    #1 rdy0 = ready;
    ncyc = 0; nwe = 0; a_lo = '1; a_hi = '1; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      ncyc++;
      if (!sram_we_n) nwe++;
      if (ncyc == 1) a_lo = sram_addr;
      if (ncyc == P + 1) a_hi = sram_addr;
      if (ready) done = 1;
    end
    wr_en = 0; rd_en = 0;
  endtask

  logic        rdy0;
  int          ncyc, nwe;
  logic [17:0] a_lo, a_hi;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 18'd0,      32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0000_0000, 18'd0,      32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1036, 32'hCAFE_F00D, 18'd6,      32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1038, 32'h0000_0000, 18'd6,      32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b1, 32'd1028, 32'h1234_5678, 18'd2,      32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b1, 32'd1028, 32'h0000_0000, 18'd2,      32'h1234_5678};
    vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0A0B_0C0D, 18'h3FFFE,  32'h1234_5678};
    vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'h0000_0000, 18'h3FFFE,  32'h0A0B_0C0D};

    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0; sram_oe = 1;
    rd_en_1 = 0; wr_en_1 = 0; address_1 = 0; write_data_1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_addr", 32'(sram_addr), 32'd0);
    check("reset_read_data", read_data, 32'd0);

    for (int k = 0; k < 8; k++) begin
      run_access(vecs[k], rdy0, ncyc, nwe, a_lo, a_hi);
      check($sformatf("v%0d_ready_cycle0", k), 32'(rdy0), 32'd0);
      check($sformatf("v%0d_done_cycle", k), 32'(ncyc), 32'(2 * P + 1));
      check($sformatf("v%0d_we_low_cycles", k), 32'(nwe), vecs[k].wr ? 32'(2 * P) : 32'd0);
      check($sformatf("v%0d_addr_lo", k), 32'(a_lo), 32'(vecs[k].exp_lo));
      check($sformatf("v%0d_addr_hi", k), 32'(a_hi), 32'(vecs[k].exp_lo | 18'd1));
      check($sformatf("v%0d_read_data", k), read_data, vecs[k].exp_rd);
      if (vecs[k].wr) begin
        check($sformatf("v%0d_mem_lo", k), 32'(mem[vecs[k].exp_lo[7:0]]), 32'(vecs[k].wdata[15:0]));
        check($sformatf("v%0d_mem_hi", k), 32'(mem[8'(vecs[k].exp_lo[7:0] + 8'd1)]),
              32'(vecs[k].wdata[31:16]));
      end
    end

    // Back-to-back loads: request held through DONE, address advanced at DONE.
    @(posedge clk); #1;
    @(negedge clk);
    rd_en = 1; address = 32'd1024;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; ncyc++;
      if (ready) break;
    end
    check("b2b_first_done", 32'(ncyc), 32'(2 * P + 1));
    check("b2b_first_data", read_data, 32'hDEAD_BEEF);
    address = 32'd1028;
    @(posedge clk); #1;
    check("b2b_idle_ready", 32'(ready), 32'd0);
    check("b2b_idle_we_n", 32'(sram_we_n), 32'd1);
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; ncyc++;
      if (ready) break;
    end
    check("b2b_second_done", 32'(ncyc), 32'(2 * P + 1));
    check("b2b_second_data", read_data, 32'h1234_5678);
    rd_en = 0;

    // Reset in the middle of an ACC_LO write.
    @(posedge clk); #1;
    @(negedge clk);
    wr_en = 1; address = 32'd1040; write_data = 32'h1111_2222; sram_oe = 0;
    @(posedge clk); #1;
    check("rst_mid_we_low", 32'(sram_we_n), 32'd0);
    @(negedge clk) begin rst = 1; wr_en = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    check("rst_mid_addr", 32'(sram_addr), 32'd0);
    check("rst_mid_read_data", read_data, 32'd0);
    check("rst_mid_dq_released", (sram_dq === 16'hzzzz || sram_dq === 16'h0000) ? 32'd1 : 32'd0, 32'd1);
    sram_oe = 1;

    // PHASE_CYCLES=1: store then load.
    for (int op = 0; op < 2; op++) begin
      @(posedge clk); #1;
      @(negedge clk);
      wr_en_1 = (op == 0); rd_en_1 = (op == 1);
      address_1 = 32'd1024; write_data_1 = 32'h55AA_33CC;
      ncyc = 0; nwe = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1; ncyc++;
        if (!sram_we_n_1) nwe++;
        if (ready_1) break;
      end
      wr_en_1 = 0; rd_en_1 = 0;
      check($sformatf("p1_op%0d_done_cycle", op), 32'(ncyc), 32'd3);
      check($sformatf("p1_op%0d_we_low", op), 32'(nwe), (op == 0) ? 32'd2 : 32'd0);
    end
    check("p1_mem_lo", 32'(mem1[0]), 32'h33CC);
    check("p1_mem_hi", 32'(mem1[1]), 32'h55AA);
    check("p1_read_data", read_data_1, 32'h55AA_33CC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
